// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response bus plus the decode-side
// valid/stall handshake and the execute redirect.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction fetch with a 2-entry return FIFO, credit-based issue and
// redirect flush that discards responses still in flight.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  logic [31:0] pc;
  logic [1:0]  outstanding, outstanding_n;
  logic [1:0]  kill;
  logic [1:0]  count, count_n;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic [31:0] fifo_pc_n    [2];
  logic [31:0] fifo_instr_n [2];
  logic [31:0] ifq_pc   [2];
  logic [31:0] ifq_pc_n [2];
  logic        pop, grant, resp, push;
  logic [2:0]  credit;

  assign pop    = (count != 2'd0) && !bus.stall;
  // Words owed by memory plus words held must stay below FIFO depth.
  assign credit = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};

  assign bus.mem_req     = !reset && !bus.redirect && (credit < 3'd2);
  assign bus.mem_addr    = pc;
  assign grant           = bus.mem_req && bus.mem_gnt;
  assign resp            = bus.mem_rvalid && (outstanding != 2'd0);
  assign push            = resp && (kill == 2'd0) && !bus.redirect;

  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = fifo_instr[0];
  assign bus.instr_pc    = fifo_pc[0];

  always_comb begin
    ifq_pc_n      = ifq_pc;
    outstanding_n = outstanding;
    if (resp) begin
      ifq_pc_n[0]   = ifq_pc[1];
      outstanding_n = outstanding_n - 2'd1;
    end
    if (grant) begin
      ifq_pc_n[outstanding_n[0]] = pc;
      outstanding_n              = outstanding_n + 2'd1;
    end
  end

  always_comb begin
    fifo_pc_n    = fifo_pc;
    fifo_instr_n = fifo_instr;
    count_n      = count;
    if (pop) begin
      fifo_pc_n[0]    = fifo_pc[1];
      fifo_instr_n[0] = fifo_instr[1];
      count_n         = count_n - 2'd1;
    end
    if (push) begin
      fifo_pc_n[count_n[0]]    = ifq_pc[0];
      fifo_instr_n[count_n[0]] = bus.mem_rdata;
      count_n                  = count_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      outstanding <= 2'd0;
      kill        <= 2'd0;
      count       <= 2'd0;
      fifo_pc     <= '{default: '0};
      fifo_instr  <= '{default: '0};
      ifq_pc      <= '{default: '0};
    end else begin
      outstanding <= outstanding_n;
      ifq_pc      <= ifq_pc_n;
      if (bus.redirect) begin
        // No grant can occur here, so outstanding_n is the post-response count.
        pc    <= {bus.redirect_pc[31:2], 2'b00};
        count <= 2'd0;
        kill  <= outstanding_n;
      end else begin
        if (grant) pc <= pc + 32'd4;
        if (resp && (kill != 2'd0)) kill <= kill - 2'd1;
        count      <= count_n;
        fifo_pc    <= fifo_pc_n;
        fifo_instr <= fifo_instr_n;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a latency-configurable memory model, expected
// {pc, instr} queued at grant and compared as decode consumes instructions.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  typedef struct { int due; logic [31:0] data; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  logic clk = 1'b0;
  logic reset;
  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  mem_t        memq[$];
  exp_t        sb[$];
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        gnt_en = 1'b0;
  logic        arm_first = 1'b0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] first_pc, last_pop_pc, h_pc, h_instr;
  logic [31:0] s_req, s_addr, s_valid, s_instr, s_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory side, sample at negedge+1, score, advance.
  task automatic step();
    mem_t m;
    exp_t e;
    bus.mem_gnt = gnt_en;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = m.data;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    s_req   = {31'b0, bus.mem_req};
    s_addr  = bus.mem_addr;
    s_valid = {31'b0, bus.instr_valid};
    s_instr = bus.instr;
    s_pc    = bus.instr_pc;
    if (reset) begin
      memq.delete();
      sb.delete();
      exp_addr = RESET_PC;
    end else begin
      if (s_req[0] && gnt_en) begin
        chk("fetch_addr", s_addr, exp_addr);
        m.due  = cyc + lat;
        m.data = exp_addr ^ K;
        memq.push_back(m);
        e.pc    = exp_addr;
        e.instr = exp_addr ^ K;
        sb.push_back(e);
        exp_addr += 32'd4;
      end
      if (bus.redirect) begin
        sb.delete();
        exp_addr = {bus.redirect_pc[31:2], 2'b00};
      end else if (s_valid[0] && !bus.stall) begin
        pops++;
        last_pop_pc = s_pc;
        if (arm_first) begin
          first_pc  = s_pc;
          arm_first = 1'b0;
        end
        if (sb.size() == 0) chk("unexpected_instr", s_valid, 32'd0);
        else begin
          e = sb.pop_front();
          chk("instr_pc", s_pc, e.pc);
          chk("instr", s_instr, e.instr);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    mem_t inj;
    reset = 1'b1;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
    @(negedge clk);

    step(); step();
    chk("rst_req", s_req, 32'd0);
    chk("rst_valid", s_valid, 32'd0);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_pc", s_pc, 32'd0);

    // Streaming with 1-cycle memory
    reset = 1'b0; gnt_en = 1'b1; pops = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        chk("rel_req", s_req, 32'd1);
        chk("rel_addr", s_addr, RESET_PC);
      end
      if (i >= 2) chk("stream_valid", s_valid, 32'd1);
    end
    chk("stream_pops", pops, 32'd8);
    chk("stream_last_pc", last_pop_pc, 32'd28);

    // Backpressure
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        h_pc = s_pc;
        h_instr = s_instr;
        chk("stall_head_pc", h_pc, 32'd32);
      end else begin
        chk("hold_pc", s_pc, h_pc);
        chk("hold_instr", s_instr, h_instr);
      end
      chk("stall_valid", s_valid, 32'd1);
      if (i >= 2) chk("stall_req", s_req, 32'd0);
    end
    bus.stall = 1'b0; pops = 0;
    for (int i = 0; i < 6; i++) step();
    chk("release_pops", pops, 32'd6);

    // Redirect coinciding with a response and a pop
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_1002;
    step();
    chk("rd_valid", s_valid, 32'd1);
    chk("rd_req", s_req, 32'd0);
    bus.redirect = 1'b0; first_pc = 32'hFFFF_FFFF; arm_first = 1'b1;
    step();
    chk("rd_flush_valid", s_valid, 32'd0);
    chk("rd_next_req", s_req, 32'd1);
    chk("rd_next_addr", s_addr, 32'h0000_1000);
    for (int i = 0; i < 6; i++) step();
    chk("rd_first_pc", first_pc, 32'h0000_1000);

    // Reset after activity, then redirect with two requests in flight
    reset = 1'b1;
    step(); step();
    chk("rst2_valid", s_valid, 32'd0);
    chk("rst2_instr", s_instr, 32'd0);
    chk("rst2_pc", s_pc, 32'd0);
    reset = 1'b0; lat = 3;
    step(); step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0803;
    step();
    chk("if_rd_req", s_req, 32'd0);
    bus.redirect = 1'b0; first_pc = 32'hFFFF_FFFF; arm_first = 1'b1;
    step();
    chk("if_flush_valid", s_valid, 32'd0);
    chk("if_addr", s_addr, 32'h0000_0800);
    for (int i = 0; i < 12; i++) step();
    chk("if_first_pc", first_pc, 32'h0000_0800);

    // Wrap-around
    lat = 1;
    for (int i = 0; i < 8; i++) step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    step();
    chk("wrap_req0", s_req, 32'd1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_req1", s_req, 32'd1);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
    step();
    chk("wrap_valid", s_valid, 32'd1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    chk("wrap_instr0", s_instr, 32'h5A5A_FFFC);
    step();
    chk("wrap_pc1", s_pc, 32'h0000_0000);
    chk("wrap_instr1", s_instr, 32'hA5A5_0000);

    // Stray response with nothing outstanding must be ignored
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    inj.due = cyc; inj.data = 32'h1234_5678;
    memq.push_back(inj);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i > 0) chk("proto_valid", s_valid, 32'd0);
    end
    gnt_en = 1'b1; pops = 0;
    for (int i = 0; i < 8; i++) step();
    chk("proto_recover_pops", pops, 32'd6);

    // Drain
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("drain_empty", sb.size(), 32'd0);
    chk("final_valid", s_valid, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the mriscv core: it generates sequential instruction addresses from a program counter and issues them to instruction memory over a request/grant, in-order response interface. It buffers returned words in a 2-entry FIFO and presents them with their PC to `instr_decode` through a valid/stall handshake. Branch and jump redirects from execute flush all buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_req`  out  1: fetch request valid.
- `mem_addr`  out  32: fetch address, always equal to the current `pc`, word-aligned.
- `mem_gnt`  in  1: memory accepts the request when `mem_req && mem_gnt`.
- `mem_rvalid`  in  1: response valid. Responses are in order, with latency ≥1 cycle after grant.
- `mem_rdata`  in  32: instruction word; sampled when `mem_rvalid` is high.
- `redirect`  in  1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: new PC; bits [1:0] are ignored and treated as 00.
- `stall`  in  1: decode does not accept the head instruction this cycle.
- `instr`  out  32: head instruction (FIFO head register).
- `instr_pc`  out  32: address of `instr`.
- `instr_valid`  out  1: head is valid (FIFO not empty).

## Operation
- **State**
  - `pc` (32).
  - `outstanding` (2 bits, 0..2): granted requests not yet answered.
  - `kill` (2 bits, 0..2): pending responses to discard.
  - FIFO: 2 entries of {pc, instr}, plus `count` (0..2).
- **Pop**: `pop = instr_valid && !stall`. Removes the head.
- **Issue**: `mem_req = !reset && !redirect && (outstanding + count - pop) < 2`. Combinational. This credit rule guarantees the FIFO never overflows.
- **Grant** (`mem_req && mem_gnt`):
  - `pc <= pc + 4`, wrapping modulo 2^32.
  - `outstanding` increments.
  - The granted address is pushed into a 2-entry in-flight PC queue.
- **Response** (`mem_rvalid`):
  - `outstanding` decrements.
  - If `kill != 0`: `kill` decrements and the data is dropped.
  - Otherwise {in-flight PC, `mem_rdata`} is pushed to the FIFO.
- **Simultaneous events**
  - Grant and response in the same cycle: `outstanding` is unchanged.
  - Push and pop in the same cycle: `count` is unchanged, and the FIFO stays ordered.
- **Redirect**
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - FIFO is cleared, so `count <= 0`.
  - `kill <=` `outstanding` after this cycle's response decrement.
  - Any `mem_rvalid` data arriving in the redirect cycle is dropped.
  - `mem_req` is 0 in the redirect cycle, so no grant can conflict with it.
  - Redirect takes priority over pop, push and grant.
- **Protocol errors**: `mem_rvalid` with `outstanding == 0` is a protocol error. It is ignored, with no state change.
- **Reset**
  - `pc <= RESET_PC`; `outstanding`, `kill` and `count` go to 0.
  - `instr` and `instr_pc` go to 0.
  - Reset during in-flight requests does not retain `kill`. The memory must be reset together with this block.

## Timing
- **Reset cycle**: `mem_req = 0`, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`. From the first cycle after `reset` deasserts, `mem_req = 1` with `mem_addr = RESET_PC`.
- **Fetch latency**: grant in cycle N, `mem_rvalid` in N+1 (1-cycle memory) → `instr_valid = 1` in N+2.
- **Throughput**: with `mem_gnt` held high, 1-cycle memory and `stall = 0`, one instruction per cycle is sustained.
- **Stall**:
  - Under `stall`, the head is held stable: `instr`, `instr_pc` and `instr_valid` do not change while `stall && instr_valid`.
  - At most 2 words are buffered; `mem_req` drops once credits are exhausted.
- **Redirect**:
  - `redirect` in cycle R → `instr_valid = 0` in R+1.
  - `mem_req = 1` with `mem_addr = redirect_pc` in R+1.
  - First new instruction is valid at R+3 with 1-cycle memory.
- **Stale data**: no stale instruction is ever presented after a redirect.

## Test plan
- **Reset**: assert `reset` for 2 cycles → all outputs 0 and `mem_req = 0`; the cycle after release, `mem_addr = RESET_PC`.
- **Streaming**: 1-cycle memory returns `mem_rdata = addr ^ 32'hA5A5_0000`, with `stall = 0` for 8 instructions → consecutive `instr_valid` with `instr_pc` 0, 4, …, 28 and matching data, one per cycle.
- **Backpressure**: `stall = 1` for 5 cycles mid-stream → head is held; `mem_req = 0` once 2 words are buffered. On release, order is preserved with no loss or duplicate.
- **Redirect with in-flight requests**: 3-cycle memory latency with 2 outstanding, then `redirect_pc = 32'h0000_0803` → both old responses are dropped, `mem_addr = 32'h800`, and the first valid `instr_pc = 32'h800`.
- **Simultaneous redirect + `mem_rvalid` + pop** → the response is discarded, the FIFO is empty next cycle, and `kill` equals the remaining outstanding count.
- **Wrap-around**: `redirect_pc = 32'hFFFF_FFFC` → the next fetch addresses are `FFFF_FFFC`, then `0000_0000`.
